// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator paced by a code-rate NCO. A chip change appears one edge after chip_strobe.
// There is no backpressure: enable=0 freezes the NCO, the LFSRs and the chip index.
module ca_code_gen #(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             prn_load,
  input  logic [5:0]       prn_sel,
  input  logic [NCO_W-1:0] code_fcw,
  output logic             chip,
  output logic [9:0]       chip_idx,
  output logic             chip_strobe,
  output logic             epoch,
  output logic             prn_err
);

  logic [NCO_W-1:0] phase;
  logic [NCO_W:0]   sum;
  logic [9:0]       g1;
  logic [9:0]       g2;
  logic [3:0]       tap1;
  logic [3:0]       tap2;
  logic [7:0]       rom_taps;
  logic             advance;
  logic             valid_sel;

  // G2 phase-select stage pairs {t1,t2} for PRN 1..32, using stage numbers 1..10
  function automatic logic [7:0] tap_rom(input logic [5:0] prn);
    case (prn)
      6'd1:  tap_rom = {4'd2, 4'd6};
      6'd2:  tap_rom = {4'd3, 4'd7};
      6'd3:  tap_rom = {4'd4, 4'd8};
      6'd4:  tap_rom = {4'd5, 4'd9};
      6'd5:  tap_rom = {4'd1, 4'd9};
      6'd6:  tap_rom = {4'd2, 4'd10};
      6'd7:  tap_rom = {4'd1, 4'd8};
      6'd8:  tap_rom = {4'd2, 4'd9};
      6'd9:  tap_rom = {4'd3, 4'd10};
      6'd10: tap_rom = {4'd2, 4'd3};
      6'd11: tap_rom = {4'd3, 4'd4};
      6'd12: tap_rom = {4'd5, 4'd6};
      6'd13: tap_rom = {4'd6, 4'd7};
      6'd14: tap_rom = {4'd7, 4'd8};
      6'd15: tap_rom = {4'd8, 4'd9};
      6'd16: tap_rom = {4'd9, 4'd10};
      6'd17: tap_rom = {4'd1, 4'd4};
      6'd18: tap_rom = {4'd2, 4'd5};
      6'd19: tap_rom = {4'd3, 4'd6};
      6'd20: tap_rom = {4'd4, 4'd7};
      6'd21: tap_rom = {4'd5, 4'd8};
      6'd22: tap_rom = {4'd6, 4'd9};
      6'd23: tap_rom = {4'd1, 4'd3};
      6'd24: tap_rom = {4'd4, 4'd6};
      6'd25: tap_rom = {4'd5, 4'd7};
      6'd26: tap_rom = {4'd6, 4'd8};
      6'd27: tap_rom = {4'd7, 4'd9};
      6'd28: tap_rom = {4'd8, 4'd10};
      6'd29: tap_rom = {4'd1, 4'd6};
      6'd30: tap_rom = {4'd2, 4'd7};
      6'd31: tap_rom = {4'd3, 4'd8};
      6'd32: tap_rom = {4'd4, 4'd9};
      default: tap_rom = {4'd2, 4'd6};
    endcase
  endfunction

  assign sum         = {1'b0, phase} + {1'b0, code_fcw};
  assign valid_sel   = (prn_sel >= 6'd1) && (prn_sel <= 6'd32);
  assign advance     = enable & sum[NCO_W] & ~prn_load & ~rst;
  assign chip_strobe = advance;
  assign epoch       = advance & (chip_idx == 10'd1022);
  // tap registers hold zero-based bit positions: stage n lives in bit n-1
  assign rom_taps    = tap_rom(prn_sel) - 8'h11;
  assign chip        = ~prn_err & (g1[9] ^ g2[tap1] ^ g2[tap2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      g1       <= '1;
      g2       <= '1;
      chip_idx <= '0;
      tap1     <= 4'd1;
      tap2     <= 4'd5;
      prn_err  <= 1'b0;
    end else if (prn_load) begin
      phase    <= '0;
      g1       <= '1;
      g2       <= '1;
      chip_idx <= '0;
      if (valid_sel) begin
        tap1    <= rom_taps[7:4];
        tap2    <= rom_taps[3:0];
        prn_err <= 1'b0;
      end else begin
        prn_err <= 1'b1;
      end
    end else begin
      if (enable) begin
        phase <= sum[NCO_W-1:0];
      end
      if (advance) begin
        // the all-ones reload on the wrap equals the natural 1023rd state
        if (chip_idx == 10'd1022) begin
          chip_idx <= '0;
          g1       <= '1;
          g2       <= '1;
        end else begin
          chip_idx <= chip_idx + 10'd1;
          g1       <= {g1[8:0], g1[2] ^ g1[9]};
          g2       <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
        end
      end
    end
  end

endmodule
